// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, opcodes and the rfread bundle.
// Branch-class opcodes (jumps, calls, returns) all have opcode bit 3 set.
package proc_pkg;

  localparam int PC_W = 6;
  localparam int IR_W = 16;

  // Opcode lives in ir[3:0]
  localparam logic [3:0] OP_ADD_X  = 4'b0000;
  localparam logic [3:0] OP_SUB_X  = 4'b0001;
  localparam logic [3:0] OP_LD_X   = 4'b0010;
  localparam logic [3:0] OP_ST_X   = 4'b0011;
  localparam logic [3:0] OP_J_X    = 4'b1000;
  localparam logic [3:0] OP_JZ_X   = 4'b1001;
  localparam logic [3:0] OP_JN_X   = 4'b1010;
  localparam logic [3:0] OP_CALL_X = 4'b1100;
  localparam logic [3:0] OP_RET_X  = 4'b1101;

  typedef struct packed {
    logic            valid;
    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred_pc;
    logic            fastcall;
  } rf_bundle_t;

  function automatic logic is_branch(input logic [3:0] op);
    return (op & 4'b1000) != 4'b0000;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: stall/redirect/predictor/imem inputs and rfread-bundle outputs.
// master = fetch stage side, slave = surrounding pipeline / testbench side.
interface fetch_stage_if #(
  parameter int PC_W = proc_pkg::PC_W,
  parameter int IR_W = proc_pkg::IR_W
);
  logic            i_stall;
  logic            i_redirect_valid;
  logic [PC_W-1:0] i_redirect_pc;
  logic [PC_W-1:0] i_pred_pc;
  logic            i_pred_fastcall;
  logic [IR_W-1:0] i_imem_rdata;
  logic [PC_W-1:0] o_current_pc;
  logic            o_fetch_valid;
  logic            o_rfread_valid;
  logic [IR_W-1:0] o_ir_rfread;
  logic [PC_W-1:0] o_pc_rfread;
  logic [PC_W-1:0] o_pred_pc_rfread;
  logic            o_fastcall_rfread;
  logic            o_is_br_instr_rfread;

  modport master (
    input  i_stall, i_redirect_valid, i_redirect_pc, i_pred_pc, i_pred_fastcall, i_imem_rdata,
    output o_current_pc, o_fetch_valid, o_rfread_valid, o_ir_rfread, o_pc_rfread,
           o_pred_pc_rfread, o_fastcall_rfread, o_is_br_instr_rfread
  );

  modport slave (
    output i_stall, i_redirect_valid, i_redirect_pc, i_pred_pc, i_pred_fastcall, i_imem_rdata,
    input  o_current_pc, o_fetch_valid, o_rfread_valid, o_ir_rfread, o_pc_rfread,
           o_pred_pc_rfread, o_fastcall_rfread, o_is_br_instr_rfread
  );
endinterface

// File: rtl/fetch_stage.sv
// PC generation + imem fetch into the rfread register; address-to-rfread 2 cycles.
// Stall holds PC/F/rfread with a 1-entry skid for imem data; redirect squashes F and rfread.
module fetch_stage #(
  parameter int              PC_W     = proc_pkg::PC_W,
  parameter int              IR_W     = proc_pkg::IR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  import proc_pkg::*;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            f_valid_q, f_valid_d;
  logic [PC_W-1:0] f_pc_q, f_pc_d;
  logic [PC_W-1:0] f_pred_q, f_pred_d;
  logic            f_fc_q, f_fc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [IR_W-1:0] skid_ir_q, skid_ir_d;
  rf_bundle_t      rf_q, rf_d;
  logic [IR_W-1:0] f_ir;

  // Once stalled, imem re-reads pc_q, so the F instruction must come from the skid
  assign f_ir = skid_valid_q ? skid_ir_q : bus.i_imem_rdata;

  always_comb begin
    pc_d         = pc_q;
    f_valid_d    = f_valid_q;
    f_pc_d       = f_pc_q;
    f_pred_d     = f_pred_q;
    f_fc_d       = f_fc_q;
    skid_valid_d = skid_valid_q;
    skid_ir_d    = skid_ir_q;
    rf_d         = rf_q;
    if (bus.i_redirect_valid) begin
      pc_d         = bus.i_redirect_pc;
      f_valid_d    = 1'b0;
      skid_valid_d = 1'b0;
      rf_d.valid   = 1'b0;
    end else if (bus.i_stall) begin
      if (f_valid_q && !skid_valid_q) begin
        skid_ir_d    = bus.i_imem_rdata;
        skid_valid_d = 1'b1;
      end
    end else begin
      rf_d.valid    = f_valid_q;
      rf_d.ir       = f_ir;
      rf_d.pc       = f_pc_q;
      rf_d.pred_pc  = f_pred_q;
      rf_d.fastcall = f_fc_q;
      skid_valid_d  = 1'b0;
      f_pc_d        = pc_q;
      f_pred_d      = bus.i_pred_pc;
      f_fc_d        = bus.i_pred_fastcall;
      f_valid_d     = 1'b1;
      pc_d          = bus.i_pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      f_valid_q    <= 1'b0;
      f_pc_q       <= '0;
      f_pred_q     <= '0;
      f_fc_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_ir_q    <= '0;
      rf_q         <= '0;
    end else begin
      pc_q         <= pc_d;
      f_valid_q    <= f_valid_d;
      f_pc_q       <= f_pc_d;
      f_pred_q     <= f_pred_d;
      f_fc_q       <= f_fc_d;
      skid_valid_q <= skid_valid_d;
      skid_ir_q    <= skid_ir_d;
      rf_q         <= rf_d;
    end
  end

  assign bus.o_current_pc         = pc_q;
  assign bus.o_fetch_valid        = !reset && !bus.i_redirect_valid && !bus.i_stall;
  assign bus.o_rfread_valid       = rf_q.valid;
  assign bus.o_ir_rfread          = rf_q.ir;
  assign bus.o_pc_rfread          = rf_q.pc;
  assign bus.o_pred_pc_rfread     = rf_q.pred_pc;
  assign bus.o_fastcall_rfread    = rf_q.fastcall;
  assign bus.o_is_br_instr_rfread = rf_q.valid && is_branch(rf_q.ir[3:0]);

endmodule
